// File: rtl/ms_uart_rx_if.sv
// Serial-line and frame-configuration signals of the UART receiver.
// master drives the line and configuration; slave is the receiver.
interface ms_uart_rx_if;
    logic       TICK;
    logic       RX;
    logic [1:0] DATASEL;
    logic [1:0] PARITYSEL;
    logic       STOPSEL;
    logic       OVRSEL;
    logic [7:0] DOUT;
    logic       DONE;
    logic       BUSY;
    logic       PERR;
    logic       FERR;

    modport master (
        output TICK, RX, DATASEL, PARITYSEL, STOPSEL, OVRSEL,
        input  DOUT, DONE, BUSY, PERR, FERR
    );

    modport slave (
        input  TICK, RX, DATASEL, PARITYSEL, STOPSEL, OVRSEL,
        output DOUT, DONE, BUSY, PERR, FERR
    );
endinterface

// File: rtl/ms_uart_rx.sv
// UART receiver: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits,
// 16x/8x oversampling driven by the TICK clock enable.
module ms_uart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESETN,
    ms_uart_rx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [3:0]             tick_cnt, tick_cnt_n;
    logic [2:0]             bit_cnt, bit_cnt_n;
    logic [7:0]             shreg, shreg_n;
    logic [1:0]             dsel_q, dsel_n;
    logic [1:0]             psel_q, psel_n;
    logic                   stop_q, stop_n;
    logic                   ovr_q, ovr_n;
    logic                   perr_i, perr_i_n;
    logic                   ferr_i, ferr_i_n;
    logic [7:0]             dout_q, dout_n;
    logic                   done_q, done_n;
    logic                   busy_q, busy_n;
    logic                   perr_q, perr_n;
    logic                   ferr_q, ferr_n;
    logic                   mid_bit, finish, ferr_fin, par_en;

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign par_en  = psel_q[0] ^ psel_q[1];
    assign mid_bit = bus.TICK && (tick_cnt == (ovr_q ? 4'd7 : 4'd15));

    assign bus.DOUT = dout_q;
    assign bus.DONE = done_q;
    assign bus.BUSY = busy_q;
    assign bus.PERR = perr_q;
    assign bus.FERR = ferr_q;

    always_ff @(posedge CLK) begin
        if (RESETN) begin
            sync_q   <= '1;
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            dsel_q   <= '0;
            psel_q   <= '0;
            stop_q   <= 1'b0;
            ovr_q    <= 1'b0;
            perr_i   <= 1'b0;
            ferr_i   <= 1'b0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.RX};
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            dsel_q   <= dsel_n;
            psel_q   <= psel_n;
            stop_q   <= stop_n;
            ovr_q    <= ovr_n;
            perr_i   <= perr_i_n;
            ferr_i   <= ferr_i_n;
            dout_q   <= dout_n;
            done_q   <= done_n;
            busy_q   <= busy_n;
            perr_q   <= perr_n;
            ferr_q   <= ferr_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        dsel_n     = dsel_q;
        psel_n     = psel_q;
        stop_n     = stop_q;
        ovr_n      = ovr_q;
        perr_i_n   = perr_i;
        ferr_i_n   = ferr_i;
        dout_n     = dout_q;
        done_n     = 1'b0;
        busy_n     = busy_q;
        perr_n     = perr_q;
        ferr_n     = ferr_q;
        finish     = 1'b0;
        ferr_fin   = ferr_i;

        if (bus.TICK) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_n    = START;
                        tick_cnt_n = '0;
                    end
                end
                START: begin
                    // Configuration is not latched yet, so the half-bit point uses the live OVRSEL.
                    if (tick_cnt == (bus.OVRSEL ? 4'd3 : 4'd7)) begin
                        if (rxs) begin
                            state_n = IDLE;
                        end else begin
                            dsel_n     = bus.DATASEL;
                            psel_n     = bus.PARITYSEL;
                            stop_n     = bus.STOPSEL;
                            ovr_n      = bus.OVRSEL;
                            busy_n     = 1'b1;
                            shreg_n    = '0;
                            tick_cnt_n = '0;
                            bit_cnt_n  = '0;
                            perr_i_n   = 1'b0;
                            ferr_i_n   = 1'b0;
                            state_n    = DATA;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
                default: begin
                    if (!mid_bit) begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end else begin
                        tick_cnt_n = '0;
                        case (state)
                            DATA: begin
                                shreg_n[bit_cnt] = rxs;
                                bit_cnt_n        = bit_cnt + 3'd1;
                                if (bit_cnt == ({1'b0, dsel_q} + 3'd4))
                                    state_n = par_en ? PARITY : STOP1;
                            end
                            PARITY: begin
                                perr_i_n = (psel_q == 2'b01) ? (rxs != ^shreg) : (rxs != ~^shreg);
                                state_n  = STOP1;
                            end
                            STOP1: begin
                                if (stop_q) begin
                                    ferr_i_n = ~rxs;
                                    state_n  = STOP2;
                                end else begin
                                    finish   = 1'b1;
                                    ferr_fin = ~rxs;
                                end
                            end
                            STOP2: begin
                                finish   = 1'b1;
                                ferr_fin = ferr_i | ~rxs;
                            end
                            default: state_n = IDLE;
                        endcase
                    end
                end
            endcase
        end

        // Frame ends at the last stop sample, not the end of the stop bit.
        if (finish) begin
            dout_n  = shreg;
            perr_n  = perr_i;
            ferr_n  = ferr_fin;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
        end
    end
endmodule

// File: tb/tb_ms_uart_rx.sv
// Self-checking bench for ms_uart_rx: directed frames with literal expectations,
// then random frames scored by a frame-level model.
module tb_ms_uart_rx;
    localparam int TDIV = 4;

    typedef struct packed {
        logic [7:0] dout;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic CLK = 1'b0;
    logic RESETN = 1'b1;
    logic rst_q = 1'b1;
    bit   tick_en = 1'b1;
    int   tick_ph = 0;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t expq[$];
    logic [7:0] hold_dout = '0;
    logic       hold_perr = 1'b0;
    logic       hold_ferr = 1'b0;

    ms_uart_rx_if bus ();

    ms_uart_rx #(.SYNC_STAGES(2)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) rst_q <= RESETN;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Oversampling enable: one CLK wide, every TDIV clocks.
    initial begin
        bus.TICK = 1'b0;
        forever begin
            @(negedge CLK);
            tick_ph  = (tick_ph + 1) % TDIV;
            bus.TICK = tick_en && (tick_ph == 0);
        end
    end

    // Compare process: every cycle, outputs must match reset values, the next
    // expected frame on DONE, or the held values of the last frame.
    initial begin
        forever begin
            @(negedge CLK);
            if (rst_q) begin
                hold_dout = '0;
                hold_perr = 1'b0;
                hold_ferr = 1'b0;
                chk("rst_dout", bus.DOUT, 0);
                chk("rst_done", bus.DONE, 0);
                chk("rst_busy", bus.BUSY, 0);
                chk("rst_perr", bus.PERR, 0);
                chk("rst_ferr", bus.FERR, 0);
            end else if (bus.DONE === 1'b1) begin
                chk("busy_at_done", bus.BUSY, 0);
                if (expq.size() == 0) begin
                    chk("done_without_frame", bus.DONE, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("dout", bus.DOUT, e.dout);
                    chk("perr", bus.PERR, e.perr);
                    chk("ferr", bus.FERR, e.ferr);
                    hold_dout = e.dout;
                    hold_perr = e.perr;
                    hold_ferr = e.ferr;
                end
            end else begin
                chk("done_idle", bus.DONE, 0);
                chk("dout_hold", bus.DOUT, hold_dout);
                chk("perr_hold", bus.PERR, hold_perr);
                chk("ferr_hold", bus.FERR, hold_ferr);
            end
        end
    end

    function automatic int bit_cycles(input int skew);
        int n;
        n = bus.OVRSEL ? 8 : 16;
        return (n * TDIV * (100 + skew) + 50) / 100;
    endfunction

    task automatic set_cfg(input logic ovr, input logic [1:0] dsel, input logic [1:0] psel,
                           input logic stopsel);
        bus.OVRSEL    = ovr;
        bus.DATASEL   = dsel;
        bus.PARITYSEL = psel;
        bus.STOPSEL   = stopsel;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.dout = d;
        e.perr = p;
        e.ferr = f;
        expq.push_back(e);
    endtask

    task automatic drive_bit(input logic v, input int cycles);
        bus.RX = v;
        repeat (cycles) @(negedge CLK);
    endtask

    // Sends one frame using the current configuration. With use_model the
    // expected result is derived from the frame definition and queued.
    task automatic send_frame(input logic [7:0] d, input bit par_flip, input logic [1:0] stop_bad,
                              input int skew, input bit use_model, input int rst_bit,
                              input bit scramble);
        int         bc, nb, nstop;
        logic [7:0] dm;
        bit         pen;
        logic       pb;
        bc    = bit_cycles(skew);
        nb    = 5 + int'(bus.DATASEL);
        dm    = '0;
        for (int i = 0; i < nb; i++) dm[i] = d[i];
        pen   = (bus.PARITYSEL == 2'b01) || (bus.PARITYSEL == 2'b10);
        pb    = ((bus.PARITYSEL == 2'b01) ? ^dm : ~^dm) ^ par_flip;
        nstop = bus.STOPSEL ? 2 : 1;
        if (use_model)
            push_exp(dm, pen && par_flip, stop_bad[0] | ((nstop == 2) && stop_bad[1]));
        chk("busy_before_start", bus.BUSY, 0);
        drive_bit(1'b0, bc);
        if (scramble)
            set_cfg(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < nb; i++) begin
            bus.RX = dm[i];
            if (i == rst_bit) begin
                repeat (bc / 2) @(negedge CLK);
                RESETN = 1'b1;
                @(negedge CLK);
                RESETN = 1'b0;
                repeat (bc - bc / 2 - 1) @(negedge CLK);
            end else if (i == 1) begin
                repeat (bc / 2) @(negedge CLK);
                chk("busy_in_frame", bus.BUSY, 1);
                repeat (bc - bc / 2) @(negedge CLK);
            end else begin
                repeat (bc) @(negedge CLK);
            end
        end
        if (pen) drive_bit(pb, bc);
        for (int s = 0; s < nstop; s++) drive_bit(~stop_bad[s], bc);
        bus.RX = 1'b1;
    endtask

    task automatic idle(input int cycles);
        bus.RX = 1'b1;
        repeat (cycles) @(negedge CLK);
    endtask

    initial begin
        bus.RX = 1'b1;
        set_cfg(1'b0, 2'b11, 2'b00, 1'b0);
        RESETN = 1'b1;
        repeat (3) @(negedge CLK);
        RESETN = 1'b0;
        idle(40);

        // 16x 8N1, 0xA5
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 2'b00, 0, 1'b0, -1, 1'b0);
        idle(64);
        chk("busy_after_frame", bus.BUSY, 0);

        // 8x 7E1, 0x53 with correct then wrong parity
        set_cfg(1'b1, 2'b10, 2'b01, 1'b0);
        push_exp(8'h53, 1'b0, 1'b0);
        send_frame(8'h53, 1'b0, 2'b00, 0, 1'b0, -1, 1'b0);
        idle(40);
        push_exp(8'h53, 1'b1, 1'b0);
        send_frame(8'h53, 1'b1, 2'b00, 0, 1'b0, -1, 1'b0);
        idle(40);

        // 16x 5O2, 0x1F, second stop bit low
        set_cfg(1'b0, 2'b00, 2'b10, 1'b1);
        push_exp(8'h1F, 1'b0, 1'b1);
        send_frame(8'h1F, 1'b0, 2'b10, 0, 1'b0, -1, 1'b0);
        idle(160);

        // Glitch shorter than half a bit
        set_cfg(1'b0, 2'b11, 2'b00, 1'b0);
        bus.RX = 1'b0;
        repeat (4 * TDIV) begin
            @(negedge CLK);
            chk("glitch_busy", bus.BUSY, 0);
        end
        bus.RX = 1'b1;
        repeat (30 * TDIV) begin
            @(negedge CLK);
            chk("glitch_busy", bus.BUSY, 0);
        end

        // Reset during data bit 3 of 0xFF, then 0x3C
        send_frame(8'hFF, 1'b0, 2'b00, 0, 1'b0, 3, 1'b0);
        idle(128);
        push_exp(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 2'b00, 0, 1'b0, -1, 1'b0);
        idle(64);

        // Back-to-back with baud skew
        push_exp(8'h00, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 2'b00, 3, 1'b0, -1, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 2'b00, -3, 1'b0, -1, 1'b0);
        idle(128);

        // Random frames
        for (int k = 0; k < 30; k++) begin
            logic [1:0] sb;
            int         sk, bc0, gap;
            bit         scr;
            set_cfg(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            sb  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            sk  = (sb != 2'b00) ? 0 : int'($urandom_range(0, 4)) - 2;
            scr = (sb == 2'b00) && ($urandom_range(0, 1) == 1);
            bc0 = bit_cycles(0);
            gap = (sb != 2'b00) ? int'($urandom_range(2 * bc0, 3 * bc0))
                                : int'($urandom_range(0, 2 * bc0));
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0, sb, sk,
                       1'b1, -1, scr);
            idle(gap);
        end

        for (int k = 0; k < 4000 && expq.size() != 0; k++) @(negedge CLK);
        chk("frames_outstanding", expq.size(), 0);
        idle(100);
        chk("busy_final", bus.BUSY, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
